dds_phase_gen: RTL and testbench

- Downstream consumer of the frequency-word registers written by the MCU bus: one instance per DA channel.
- Takes the two 16-bit frequency-word halves and debounces/commits them as one 32-bit tuning word.
- Runs a phase accumulator and adds a phase offset.
- Folds the phase onto a quarter-wave sine ROM and rebuilds an offset-binary DAC sample.

---
 rtl/dds_phase_gen_if.sv | 46 ++++
 rtl/dds_phase_gen.sv | 126 ++++++++++++
 tb/tb_dds_phase_gen.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/dds_phase_gen_if.sv
// DDS channel bus: frequency-word inputs, phase controls,
// quarter-wave ROM port and DAC sample output.
interface dds_phase_gen_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 14
);
    logic              EN;
    logic              PHASE_CLR;
    logic [15:0]       FREQ_H;
    logic [15:0]       FREQ_L;
    logic [15:0]       PHASE_OFS;
    logic [ADDR_W-3:0] ROM_ADDR;
    logic [DATA_W-2:0] ROM_DATA;
    logic [DATA_W-1:0] DA_DATA;
    logic              DA_VALID;
    logic [31:0]       FREQ_ACT;
    logic              FW_PENDING;

    modport master (
        output EN,
        output PHASE_CLR,
        output FREQ_H,
        output FREQ_L,
        output PHASE_OFS,
        output ROM_DATA,
        input  ROM_ADDR,
        input  DA_DATA,
        input  DA_VALID,
        input  FREQ_ACT,
        input  FW_PENDING
    );

    modport slave (
        input  EN,
        input  PHASE_CLR,
        input  FREQ_H,
        input  FREQ_L,
        input  PHASE_OFS,
        input  ROM_DATA,
        output ROM_ADDR,
        output DA_DATA,
        output DA_VALID,
        output FREQ_ACT,
        output FW_PENDING
    );
endinterface

// File: rtl/dds_phase_gen.sv
// DDS phase generator: debounced tuning word, phase accumulator,
// quarter-wave fold and offset-binary DAC sample rebuild.
module dds_phase_gen #(
    parameter int ACC_W      = 32,
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 14,
    parameter int STABLE_CYC = 4
) (
    input logic            CLK,
    input logic            RST_N,
    dds_phase_gen_if.slave bus
);
    localparam int CNT_W = $clog2(STABLE_CYC + 1);
    localparam int IDX_W = ADDR_W - 2;
    localparam logic [DATA_W-1:0] MID = DATA_W'(1) << (DATA_W - 1);

    logic [31:0]       word;
    logic [31:0]       cand_q;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic              match;
    logic [31:0]       freq_act;

    logic [ACC_W-1:0]  acc;
    logic              en0;

    logic [ADDR_W-1:0] ph_hi;
    logic [1:0]        quad;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  rom_addr;
    logic              sign1;
    logic              v1;

    logic              sign2;
    logic              v2;

    logic [DATA_W-1:0] rom_ext;
    logic [DATA_W-1:0] da_data;
    logic              da_valid;

    assign word  = {bus.FREQ_H, bus.FREQ_L};
    assign match = (word == cand_q);

    always_comb begin
        cnt_nxt = '0;
        if (match) begin
            if (cnt == CNT_W'(STABLE_CYC))
                cnt_nxt = cnt;
            else
                cnt_nxt = cnt + 1'b1;
        end
    end

    // A word commits only after it has been seen STABLE_CYC+1 times.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            cand_q   <= '0;
            cnt      <= '0;
            freq_act <= '0;
        end else begin
            cand_q <= word;
            cnt    <= cnt_nxt;
            if (match && cnt == CNT_W'(STABLE_CYC - 1))
                freq_act <= cand_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            acc <= '0;
            en0 <= 1'b0;
        end else begin
            en0 <= bus.EN;
            if (bus.PHASE_CLR)
                acc <= '0;
            else if (bus.EN)
                acc <= acc + ACC_W'(freq_act);
        end
    end

    // Only the top ADDR_W bits of the offset phase drive the fold.
    assign ph_hi = ADDR_W'((acc[ACC_W-1 -: 16] + bus.PHASE_OFS)
                           >> (16 - ADDR_W));
    assign quad  = ph_hi[ADDR_W-1 -: 2];
    assign idx   = ph_hi[IDX_W-1:0];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            rom_addr <= '0;
            sign1    <= 1'b0;
            v1       <= 1'b0;
        end else begin
            rom_addr <= quad[0] ? ~idx : idx;
            sign1    <= quad[1];
            v1       <= en0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sign2 <= 1'b0;
            v2    <= 1'b0;
        end else begin
            sign2 <= sign1;
            v2    <= v1;
        end
    end

    assign rom_ext = {1'b0, bus.ROM_DATA};

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            da_data  <= MID;
            da_valid <= 1'b0;
        end else begin
            da_data  <= sign2 ? MID - rom_ext : MID + rom_ext;
            da_valid <= v2;
        end
    end

    assign bus.ROM_ADDR   = rom_addr;
    assign bus.DA_DATA    = da_data;
    assign bus.DA_VALID   = da_valid;
    assign bus.FREQ_ACT   = freq_act;
    assign bus.FW_PENDING = (cand_q != freq_act);
endmodule

// File: tb/tb_dds_phase_gen.sv
// Directed bench for dds_phase_gen: reset, commit, glitch reject,
// quadrant fold, offset/clear and wrap/enable behaviour.
module tb_dds_phase_gen;
    logic CLK;
    logic RST_N;
    int   n_cmp;
    int   n_err;

    dds_phase_gen_if #(.ADDR_W(10), .DATA_W(14)) bus ();

    dds_phase_gen #(
        .ACC_W(32), .ADDR_W(10), .DATA_W(14), .STABLE_CYC(4)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [12:0] rom(input logic [7:0] a);
        return (a == 8'hFF) ? 13'h1FFF : {a, 5'b0};
    endfunction

    // Registered ROM model: data one cycle after address.
    always @(posedge CLK) bus.ROM_DATA <= rom(bus.ROM_ADDR);

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    logic [7:0]  q_addr [4] = '{8'd0, 8'd255, 8'd0, 8'd255};
    logic        q_sign [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [13:0] q_da   [4] = '{14'h2000, 14'h3FFF, 14'h2000, 14'h0001};

    initial begin
        n_cmp = 0;
        n_err = 0;

        RST_N         = 1'b0;
        bus.FREQ_H    = 16'h1234;
        bus.FREQ_L    = 16'h1234;
        bus.EN        = 1'b1;
        bus.PHASE_CLR = 1'b0;
        bus.PHASE_OFS = 16'h0000;
        step(3);
        chk("rst_da", 32'(bus.DA_DATA), 32'h2000);
        chk("rst_valid", 32'(bus.DA_VALID), 32'h0);
        chk("rst_act", bus.FREQ_ACT, 32'h0);
        chk("rst_addr", 32'(bus.ROM_ADDR), 32'h0);
        chk("rst_pend", 32'(bus.FW_PENDING), 32'h0);

        RST_N         = 1'b1;
        bus.FREQ_H    = 16'h0100;
        bus.FREQ_L    = 16'h0000;
        bus.EN        = 1'b0;
        bus.PHASE_CLR = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step(1);
            chk("commit_act", bus.FREQ_ACT,
                (i >= 5) ? 32'h0100_0000 : 32'h0);
            chk("commit_pend", 32'(bus.FW_PENDING), (i < 5) ? 32'h1 : 32'h0);
        end

        bus.FREQ_H = 16'h0001;
        bus.FREQ_L = 16'h0000;
        step(5);
        chk("glitch_base", bus.FREQ_ACT, 32'h0001_0000);
        bus.FREQ_H = 16'h0002;
        for (int j = 1; j <= 7; j++) begin
            if (j == 3) bus.FREQ_L = 16'h8000;
            step(1);
            chk("glitch_act", bus.FREQ_ACT,
                (j >= 7) ? 32'h0002_8000 : 32'h0001_0000);
        end

        bus.FREQ_H = 16'h4000;
        bus.FREQ_L = 16'h0000;
        step(5);
        chk("quad_act", bus.FREQ_ACT, 32'h4000_0000);
        bus.PHASE_CLR = 1'b0;
        bus.EN        = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            if (k <= 4) begin
                chk("quad_addr", 32'(bus.ROM_ADDR), 32'(q_addr[k-1]));
                chk("quad_sign", 32'(dut.sign1), 32'(q_sign[k-1]));
            end
            if (k >= 3)
                chk("quad_da", 32'(bus.DA_DATA), 32'(q_da[k-3]));
            chk("quad_valid", 32'(bus.DA_VALID), (k >= 4) ? 32'h1 : 32'h0);
        end

        bus.FREQ_H    = 16'h0000;
        bus.FREQ_L    = 16'h0000;
        bus.PHASE_OFS = 16'h4000;
        bus.PHASE_CLR = 1'b1;
        bus.EN        = 1'b1;
        step(1);
        chk("clr_wins", dut.acc, 32'h0);
        step(4);
        chk("ofs_act", bus.FREQ_ACT, 32'h0);
        chk("ofs_acc", dut.acc, 32'h0);
        chk("ofs_addr", 32'(bus.ROM_ADDR), 32'd255);
        chk("ofs_sign", 32'(dut.sign1), 32'h0);
        chk("ofs_da", 32'(bus.DA_DATA), 32'h3FFF);
        chk("clr_valid", 32'(bus.DA_VALID), 32'h1);

        bus.FREQ_H = 16'hFFFF;
        bus.FREQ_L = 16'hFFFF;
        step(5);
        chk("wrap_act", bus.FREQ_ACT, 32'hFFFF_FFFF);
        bus.PHASE_CLR = 1'b0;
        bus.PHASE_OFS = 16'h1000;
        for (int w = 1; w <= 3; w++) begin
            step(1);
            chk("wrap_acc", dut.acc, 32'h0 - 32'(w));
        end
        bus.EN = 1'b0;
        for (int h = 1; h <= 5; h++) begin
            step(1);
            chk("hold_acc", dut.acc, 32'hFFFF_FFFD);
            chk("hold_addr", 32'(bus.ROM_ADDR), 32'd63);
            chk("hold_da", 32'(bus.DA_DATA), 32'h27E0);
            chk("hold_valid", 32'(bus.DA_VALID), (h < 4) ? 32'h1 : 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
